// File: rtl/block_slider.sv
// block_slider -- control core of a "stack the blocks" game.
//
// A block of width cur_w sweeps left/right across a SCREEN_W-pixel playfield,
// moving STEP pixels on every rising edge of tick. A drop press freezes it and
// the overlap with the previously placed block (initially a centred base block
// of width INIT_W) becomes the next placed block and the width of the next
// moving block. No overlap ends the game; MAX_LEVEL placed blocks wins it.
//
// Ports
//   clk, resetn      clock (rising edge), synchronous active-low reset
//   tick             pacing strobe; only its rising edge moves the block
//   start            start/restart button (rising edge, IDLE or OVER only)
//   drop             drop button (rising edge, MOVE only)
//   x_pos, cur_w     left edge and width of the moving block
//   dir              1 = moving right, 0 = moving left
//   level            number of blocks placed this game
//   place_valid      one-cycle strobe qualifying place_x / place_w
//   place_x, place_w left edge and width of the block just placed
//   game_over, win   game ended / ended by reaching MAX_LEVEL
//   state_dbg        FSM state: 0 IDLE, 1 MOVE, 2 CHECK, 3 PLACE, 4 OVER
//
// Handshake: place_valid is a strobe with no back-pressure; place_x/place_w
// are valid exactly in the cycle place_valid is high and hold afterwards.

module block_slider #(
  parameter int SCREEN_W  = 160,
  parameter int INIT_W    = 40,
  parameter int STEP      = 1,
  parameter int MAX_LEVEL = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       drop,
  output logic [7:0] x_pos,
  output logic [7:0] cur_w,
  output logic       dir,
  output logic [4:0] level,
  output logic       place_valid,
  output logic [7:0] place_x,
  output logic [7:0] place_w,
  output logic       game_over,
  output logic       win,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_CHECK = 3'd2,
    S_PLACE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_W);
  localparam logic [7:0] INIT_W8    = 8'(INIT_W);
  localparam logic [7:0] STEP8      = 8'(STEP);
  localparam logic [4:0] MAX_LVL5   = 5'(MAX_LEVEL);
  localparam logic [7:0] BASE_X     = 8'((SCREEN_W - INIT_W) / 2);

  state_t     state_q;
  logic [7:0] x_q, w_q, prev_x_q, prev_w_q, place_x_q, place_w_q;
  logic       dir_q, place_valid_q, over_q, win_q;
  logic [4:0] level_q;
  logic       tick_q, start_q, drop_q;
  // Low for the first cycle after reset so a button already held at reset
  // release is absorbed into the edge-detect registers instead of firing.
  logic       armed_q;

  logic       tick_rise, start_rise, drop_rise;
  logic [9:0] right_sum;
  logic [7:0] lo;
  logic [8:0] hi, cur_end, prev_end;
  logic [7:0] ovl_w;

  assign tick_rise  = armed_q & tick  & ~tick_q;
  assign start_rise = armed_q & start & ~start_q;
  assign drop_rise  = armed_q & drop  & ~drop_q;

  // Edge arithmetic is widened so no intermediate sum wraps.
  assign right_sum = {2'b00, x_q} + {2'b00, w_q} + {2'b00, STEP8};
  assign cur_end   = {1'b0, x_q} + {1'b0, w_q};
  assign prev_end  = {1'b0, prev_x_q} + {1'b0, prev_w_q};
  assign lo        = (x_q > prev_x_q) ? x_q : prev_x_q;
  assign hi        = (cur_end < prev_end) ? cur_end : prev_end;
  assign ovl_w     = 8'(hi - {1'b0, lo});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      w_q           <= '0;
      dir_q         <= 1'b0;
      level_q       <= '0;
      place_valid_q <= 1'b0;
      place_x_q     <= '0;
      place_w_q     <= '0;
      over_q        <= 1'b0;
      win_q         <= 1'b0;
      prev_x_q      <= '0;
      prev_w_q      <= '0;
      tick_q        <= 1'b0;
      start_q       <= 1'b0;
      drop_q        <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      armed_q       <= 1'b1;
      tick_q        <= tick;
      start_q       <= start;
      drop_q        <= drop;
      place_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            state_q  <= S_MOVE;
            x_q      <= '0;
            dir_q    <= 1'b1;
            w_q      <= INIT_W8;
            level_q  <= '0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
            prev_x_q <= BASE_X;
            prev_w_q <= INIT_W8;
          end
        end
        S_MOVE: begin
          // Drop wins over a coincident tick: the frozen position is the
          // one the player saw when pressing.
          if (drop_rise) begin
            state_q <= S_CHECK;
          end else if (tick_rise) begin
            if (dir_q) begin
              if (right_sum <= SCREEN_W10) x_q <= x_q + STEP8;
              else                         dir_q <= 1'b0;
            end else begin
              if (x_q >= STEP8) x_q <= x_q - STEP8;
              else              dir_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (hi <= {1'b0, lo}) begin
            state_q <= S_OVER;
            over_q  <= 1'b1;
            win_q   <= 1'b0;
          end else begin
            // Placement bookkeeping is registered here so it is visible in
            // the PLACE cycle alongside the strobe.
            state_q       <= S_PLACE;
            place_valid_q <= 1'b1;
            place_x_q     <= lo;
            place_w_q     <= ovl_w;
            level_q       <= level_q + 5'd1;
            prev_x_q      <= lo;
            prev_w_q      <= ovl_w;
          end
        end
        S_PLACE: begin
          if (level_q == MAX_LVL5) begin
            state_q <= S_OVER;
            over_q  <= 1'b1;
            win_q   <= 1'b1;
          end else begin
            state_q <= S_MOVE;
            x_q     <= '0;
            dir_q   <= 1'b1;
            w_q     <= prev_w_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_pos       = x_q;
  assign cur_w       = w_q;
  assign dir         = dir_q;
  assign level       = level_q;
  assign place_valid = place_valid_q;
  assign place_x     = place_x_q;
  assign place_w     = place_w_q;
  assign game_over   = over_q;
  assign win         = win_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_block_slider.sv
// Self-checking bench for block_slider: directed scenarios followed by
// randomized games, compared against a behavioural model of the game rules.
module tb_block_slider;

  localparam int SW = 160;
  localparam int IW = 40;
  localparam int ST = 1;
  localparam int ML = 20;

  localparam int ST_IDLE  = 0;
  localparam int ST_MOVE  = 1;
  localparam int ST_CHECK = 2;
  localparam int ST_OVER  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0, tick = 1'b0, start = 1'b0, drop = 1'b0;

  logic [7:0] x_pos, cur_w, place_x, place_w;
  logic       dir, place_valid, game_over, win;
  logic [4:0] level;
  logic [2:0] state_dbg;

  logic [7:0] x_pos2, cur_w2, place_x2, place_w2;
  logic       dir2, place_valid2, game_over2, win2;
  logic [4:0] level2;
  logic [2:0] state_dbg2;

  block_slider dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .drop(drop),
    .x_pos(x_pos), .cur_w(cur_w), .dir(dir), .level(level),
    .place_valid(place_valid), .place_x(place_x), .place_w(place_w),
    .game_over(game_over), .win(win), .state_dbg(state_dbg)
  );

  block_slider #(.MAX_LEVEL(2)) dut2 (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .drop(drop),
    .x_pos(x_pos2), .cur_w(cur_w2), .dir(dir2), .level(level2),
    .place_valid(place_valid2), .place_x(place_x2), .place_w(place_w2),
    .game_over(game_over2), .win(win2), .state_dbg(state_dbg2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // behavioural model of the game rules
  int m_x, m_dir, m_w, m_lvl, m_px, m_pw;
  bit m_moving, m_over, m_win;

  // scoreboard: expected placements {x, w} in order
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (resetn && place_valid) begin
      chk("place_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("sb_place", {place_x, place_w}, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    m_x = 0; m_dir = 0; m_w = 0; m_lvl = 0; m_px = 0; m_pw = 0;
    m_moving = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_start();
    if (!m_moving) begin
      m_moving = 1; m_over = 0; m_win = 0;
      m_x = 0; m_dir = 1; m_w = IW; m_lvl = 0;
      m_px = (SW - IW) / 2; m_pw = IW;
    end
  endtask

  task automatic model_tick();
    if (m_moving) begin
      if (m_dir == 1) begin
        if (m_x + m_w + ST <= SW) m_x = m_x + ST; else m_dir = 0;
      end else begin
        if (m_x >= ST) m_x = m_x - ST; else m_dir = 1;
      end
    end
  endtask

  task automatic model_drop(output bit placed);
    int lo, hi;
    lo = (m_x > m_px) ? m_x : m_px;
    hi = (m_x + m_w < m_px + m_pw) ? m_x + m_w : m_px + m_pw;
    placed = (hi > lo);
    m_moving = 0;
    if (placed) begin
      m_px = lo; m_pw = hi - lo; m_lvl++;
      exp_q.push_back({8'(m_px), 8'(m_pw)});
      if (m_lvl == ML) begin
        m_over = 1; m_win = 1;
      end else begin
        m_moving = 1; m_x = 0; m_dir = 1; m_w = m_pw;
      end
    end else begin
      m_over = 1; m_win = 0;
    end
  endtask

  // driver tasks (inputs change 1 time unit after the active edge)
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 0; tick = 0; start = 0; drop = 0;
    repeat (2) cyc();
    resetn = 1;
    cyc();
    model_reset();
  endtask

  task automatic do_start();
    model_start();
    start = 1; cyc(); start = 0; cyc();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      model_tick();
      tick = 1; cyc(); tick = 0; cyc();
    end
  endtask

  // drop, then return in the cycle two after the press (PLACE or OVER)
  task automatic do_drop(output bit placed);
    model_drop(placed);
    drop = 1; cyc(); drop = 0; cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_w"}, cur_w, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_pv"}, place_valid, 0);
    chk({tag, "_px"}, place_x, 0);
    chk({tag, "_pw"}, place_w, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  bit placed;
  int rounds;

  initial begin
    model_reset();
    // reset with start held high: release must not start a game
    resetn = 0; start = 1;
    repeat (3) cyc();
    chk_zero("reset");
    resetn = 1;
    repeat (3) cyc();
    chk("held_start_no_edge", state_dbg, ST_IDLE);
    start = 0; cyc();

    // 60 ticks, perfect drop
    do_start();
    chk("start_state", state_dbg, ST_MOVE);
    chk("start_w", cur_w, IW);
    chk("start_dir", dir, 1);
    do_ticks(60);
    chk("t60_x", x_pos, 60);
    do_drop(placed);
    chk("d60_pv", place_valid, 1);
    chk("d60_px", place_x, 60);
    chk("d60_pw", place_w, 40);
    chk("d60_level", level, 1);
    cyc();
    chk("d60_pv_clear", place_valid, 0);
    chk("d60_next_state", state_dbg, ST_MOVE);
    chk("d60_next_x", x_pos, 0);
    chk("d60_next_w", cur_w, 40);

    // start is ignored in MOVE
    do_start();
    chk("start_ignored_level", level, 1);

    // 70 ticks: partial overlap
    do_reset();
    do_start();
    do_ticks(70);
    do_drop(placed);
    chk("d70_px", place_x, 70);
    chk("d70_pw", place_w, 30);
    cyc();
    chk("d70_next_w", cur_w, 30);

    // 10 ticks: miss
    do_reset();
    do_start();
    do_ticks(10);
    do_drop(placed);
    chk("miss_pv", place_valid, 0);
    chk("miss_over", game_over, 1);
    chk("miss_win", win, 0);
    chk("miss_x_held", x_pos, 10);
    do_ticks(3);
    chk("over_ignores_tick", x_pos, 10);
    do_start();
    chk("restart_state", state_dbg, ST_MOVE);
    chk("restart_level", level, 0);
    chk("restart_over", game_over, 0);

    // right wall bounce
    do_reset();
    do_start();
    do_ticks(121);
    chk("wall_x", x_pos, 120);
    chk("wall_dir", dir, 0);
    do_ticks(1);
    chk("wall_back_x", x_pos, 119);

    // tick held high counts once
    model_tick();
    tick = 1; repeat (50) cyc(); tick = 0; cyc();
    chk("held_tick_x", x_pos, m_x);
    chk("held_tick_x_abs", x_pos, 118);
    // drop coincident with tick edge
    model_drop(placed);
    tick = 1; drop = 1; cyc();
    chk("coinc_state", state_dbg, ST_CHECK);
    chk("coinc_x", x_pos, 118);
    tick = 0; drop = 0; cyc();
    chk("coinc_over", game_over, 1);
    chk("coinc_state_over", state_dbg, ST_OVER);

    // MAX_LEVEL=2 win on dut2, then reset mid-MOVE on dut
    do_reset();
    do_start();
    do_ticks(60);
    do_drop(placed);
    chk("win_pv1", place_valid2, 1);
    chk("win_lvl1", level2, 1);
    cyc();
    do_ticks(60);
    do_drop(placed);
    chk("win_pv2", place_valid2, 1);
    chk("win_lvl2", level2, 2);
    chk("win_px2", place_x2, 60);
    cyc();
    chk("win_over", game_over2, 1);
    chk("win_win", win2, 1);
    chk("nowin_state", state_dbg, ST_MOVE);
    chk("nowin_over", game_over, 0);
    do_ticks(5);
    resetn = 0; cyc();
    chk_zero("midmove_reset");
    resetn = 1; cyc();
    model_reset();

    // randomized games
    for (int g = 0; g < 6; g++) begin
      do_reset();
      do_start();
      rounds = 0;
      while (m_moving && rounds < ML) begin
        do_ticks($urandom_range(0, 130));
        chk("rnd_x", x_pos, m_x);
        chk("rnd_dir", dir, m_dir);
        do_drop(placed);
        chk("rnd_level", level, m_lvl);
        chk("rnd_pv", place_valid, placed);
        if (placed) begin
          chk("rnd_px", place_x, m_px);
          chk("rnd_pw", place_w, m_pw);
        end
        cyc();
        chk("rnd_over", game_over, m_over);
        chk("rnd_win", win, m_win);
        if (m_moving) chk("rnd_next_w", cur_w, m_w);
        rounds++;
      end
    end

    cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
